mux_2_1_arbiter: RTL and testbench

Round-robin arbiter that shares the single-bit `mux_2_1` datapath between two requesters. Each requester raises a request and presents one data bit. The arbiter grants one requester at a time, drives the mux select, and registers the routed bit with a valid flag. Grant tenure is bounded by a parameter, so a persistent requester cannot starve the other. It sits directly in front of the existing 2:1 mux and is its only source of `sel`.

---
 rtl/mux_2_1_arbiter_pkg.sv | 18 +
 rtl/mux_2_1.sv | 13 +
 rtl/mux_2_1_arbiter.sv | 87 ++++++++
 tb/tb_mux_2_1_arbiter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mux_2_1_arbiter_pkg.sv
// mux_2_1_arbiter_pkg: shared state encodings, requester ids and select constants
package mux_2_1_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT1 = 2'd1,
      GNT2 = 2'd2
   } state_t;

   typedef enum logic {
      REQ1 = 1'b0,
      REQ2 = 1'b1
   } req_id_t;

   localparam logic SEL_IN1 = 1'b1;
   localparam logic SEL_IN2 = 1'b0;

endpackage

// File: rtl/mux_2_1.sv
// mux_2_1: single-bit 2:1 mux, sel high routes in_1
module mux_2_1
   import mux_2_1_arbiter_pkg::*;
(
   input  logic in_1,
   input  logic in_2,
   input  logic sel,
   output logic out
);

   assign out = (sel == SEL_IN1) ? in_1 : in_2;

endmodule

// File: rtl/mux_2_1_arbiter.sv
// mux_2_1_arbiter: round-robin arbiter with bounded tenure driving the 2:1 mux select
module mux_2_1_arbiter
   import mux_2_1_arbiter_pkg::*;
#(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 4
)
(
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic req_1,
   input  logic req_2,
   input  logic in_1,
   input  logic in_2,
   output logic gnt_1,
   output logic gnt_2,
   output logic sel,
   output logic out,
   output logic out_vld
);

   localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD - 1);

   state_t           state;
   state_t           state_nxt;
   req_id_t          last;
   logic [CNT_W-1:0] hold_cnt;
   logic             hold_done;
   logic             mux_out;
   logic             granted;

   assign hold_done = (hold_cnt == HOLD_MAX);
   assign granted   = gnt_1 | gnt_2;

   mux_2_1 mux_2_1_inst (
      .in_1 (in_1),
      .in_2 (in_2),
      .sel  (sel),
      .out  (mux_out)
   );

   // state, tenure counter and last-granted requester
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state    <= IDLE;
         hold_cnt <= '0;
         last     <= REQ2;
      end else begin
         state    <= state_nxt;
         hold_cnt <= (state_nxt != state) ? '0 :
                     (state != IDLE && !hold_done) ? hold_cnt + 1'b1 : hold_cnt;
         last     <= (state_nxt == GNT1 && state != GNT1) ? REQ1 :
                     (state_nxt == GNT2 && state != GNT2) ? REQ2 : last;
      end
   end

   // a holder keeps the grant unless it drops or its tenure expires with the other side waiting
   always_comb begin
      state_nxt = IDLE;
      case (state)
         IDLE:    state_nxt = (req_1 && req_2) ? ((last == REQ1) ? GNT2 : GNT1) :
                              req_1 ? GNT1 : req_2 ? GNT2 : IDLE;
         GNT1:    state_nxt = (req_1 && !(req_2 && hold_done)) ? GNT1 : req_2 ? GNT2 : IDLE;
         GNT2:    state_nxt = (req_2 && !(req_1 && hold_done)) ? GNT2 : req_1 ? GNT1 : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // grants and mux select decode straight from the state register
   always_comb begin
      gnt_1 = (state == GNT1);
      gnt_2 = (state == GNT2);
      sel   = gnt_1 ? SEL_IN1 : SEL_IN2;
   end

   // register the routed bit, forced to 0 while nothing is granted
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         out     <= 1'b0;
         out_vld <= 1'b0;
      end else begin
         out     <= granted & mux_out;
         out_vld <= granted;
      end
   end

endmodule

// File: tb/tb_mux_2_1_arbiter.sv
// tb_mux_2_1_arbiter: scoreboard bench with a tenure-level reference model
module tb_mux_2_1_arbiter;

   localparam int MAX_HOLD = 8;

   logic sys_clk = 1'b0;
   logic sys_rst;
   logic req_1, req_2, in_1, in_2;
   logic gnt_1, gnt_2, sel, out, out_vld;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic g1;
      logic g2;
      logic s;
      logic v;
   } exp_t;

   exp_t gq[$];
   logic dq[$];

   int owner;
   int run;
   int last_id;

   always #5 sys_clk = ~sys_clk;

   mux_2_1_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .req_1   (req_1),
      .req_2   (req_2),
      .in_1    (in_1),
      .in_2    (in_2),
      .gnt_1   (gnt_1),
      .gnt_2   (gnt_2),
      .sel     (sel),
      .out     (out),
      .out_vld (out_vld)
   );

   task automatic check(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s at %0t: got %0b expected %0b", name, $time, act, req);
      end
   endtask

   task automatic model_reset();
      owner   = 0;
      run     = 0;
      last_id = 2;
      gq.delete();
      dq.delete();
   endtask

   // owner holds for at most MAX_HOLD cycles while the other requester waits
   task automatic model_step();
      int   nxt;
      int   prev;
      int   oid;
      logic mine;
      logic other;
      prev = owner;
      if (owner == 0) begin
         nxt = (req_1 && req_2) ? ((last_id == 1) ? 2 : 1) : req_1 ? 1 : req_2 ? 2 : 0;
      end else begin
         mine  = (owner == 1) ? req_1 : req_2;
         other = (owner == 1) ? req_2 : req_1;
         oid   = 3 - owner;
         if (!mine) nxt = other ? oid : 0;
         else if (other && run >= MAX_HOLD) nxt = oid;
         else nxt = owner;
      end
      if (nxt != owner) begin
         run = (nxt != 0) ? 1 : 0;
         if (nxt != 0) last_id = nxt;
      end else if (owner != 0) begin
         run++;
      end
      gq.push_back('{g1: nxt == 1, g2: nxt == 2, s: nxt == 1, v: prev != 0});
      if (prev != 0) dq.push_back((prev == 1) ? in_1 : in_2);
      owner = nxt;
   endtask

   task automatic cycle(input logic r1, input logic r2, input logic i1, input logic i2);
      req_1 = r1;
      req_2 = r2;
      in_1  = i1;
      in_2  = i2;
      @(posedge sys_clk);
      model_step();
      #1;
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_gnt_1"}, gnt_1, 1'b0);
      check({tag, "_gnt_2"}, gnt_2, 1'b0);
      check({tag, "_sel"}, sel, 1'b0);
      check({tag, "_out"}, out, 1'b0);
      check({tag, "_out_vld"}, out_vld, 1'b0);
   endtask

   // monitor: compare grants every cycle, pop data whenever the DUT shows a valid output
   always @(negedge sys_clk) begin
      exp_t e;
      if (!sys_rst && gq.size() > 0) begin
         e = gq.pop_front();
         check("gnt_1", gnt_1, e.g1);
         check("gnt_2", gnt_2, e.g2);
         check("sel", sel, e.s);
         check("out_vld", out_vld, e.v);
         if (out_vld) begin
            if (dq.size() == 0) check("out_unexpected_valid", out_vld, 1'b0);
            else check("out", out, dq.pop_front());
         end else begin
            if (e.v && dq.size() > 0) void'(dq.pop_front());
            check("out_idle", out, 1'b0);
         end
      end
   end

   initial begin
      logic r1;
      logic r2;
      logic t;
      sys_rst = 1'b1;
      req_1   = 1'b1;
      req_2   = 1'b1;
      in_1    = 1'b1;
      in_2    = 1'b1;
      model_reset();
      repeat (3) begin
         @(negedge sys_clk);
         check_cleared("reset");
      end
      #2 sys_rst = 1'b0;
      repeat (3) cycle(1, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat (3) cycle(0, 0, 1, 1);
      t = 1'b0;
      for (int i = 0; i < 20; i++) begin
         t = ~t;
         cycle(0, 1, 1'($urandom_range(0, 1)), t);
      end
      repeat (3) cycle(0, 0, 1, 1);
      repeat (40) cycle(1, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat (3) cycle(0, 0, 0, 0);
      repeat (2) cycle(1, 0, 1, 0);
      cycle(1, 1, 0, 1);
      repeat (3) cycle(0, 1, 1, 0);
      repeat (12) cycle(1, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat (3) cycle(0, 0, 0, 0);
      repeat (4) cycle(0, 1, 0, 1);
      repeat (2) cycle(1, 1, 0, 1);
      #1 sys_rst = 1'b1;
      #1 check_cleared("mid_reset");
      model_reset();
      @(negedge sys_clk);
      check_cleared("mid_reset_hold");
      #1 sys_rst = 1'b0;
      repeat (4) cycle(1, 1, 1, 0);
      r1 = 1'b1;
      r2 = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 15) == 0) r1 = ~r1;
         if ($urandom_range(0, 15) == 0) r2 = ~r2;
         cycle(r1, r2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      repeat (2) @(negedge sys_clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
